// File: rtl/maips_pipeline_pkg.sv
// Shared pipeline types for the fetch/decode boundary.
// Holds the queued entry layout and the idle values shown to decode.
package maips_pipeline_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;
   localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// Entry storage for the fetch queue: one write port, one async read port.
// The data array is intentionally left without reset; occupancy lives outside.
module fetch_queue_mem
   import maips_pipeline_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic         clk,
   input  logic         wr_en,
   input  logic [AW-1:0] wr_addr,
   input  fetch_entry_t wr_data,
   input  logic [AW-1:0] rd_addr,
   output fetch_entry_t rd_data
);

   fetch_entry_t mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction queue with single-cycle flush on redirect.
// Define FETCH_QUEUE_BYPASS_EN to forward a push straight to decode when empty.
module fetch_queue #(
   parameter int DEPTH = 4,
   parameter int XLEN  = 32
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       push_valid,
   output logic                       push_ready,
   input  logic [XLEN-1:0]            push_pc,
   input  logic [XLEN-1:0]            push_instr,
   output logic                       pop_valid,
   input  logic                       pop_ready,
   output logic [XLEN-1:0]            pop_pc,
   output logic [XLEN-1:0]            pop_instr,
   output logic [XLEN-1:0]            pop_pc_add8,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   import maips_pipeline_pkg::*;

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] cnt;
   logic          stored;
   logic          byp;
   logic          push_fire;
   logic          pop_fire;
   logic          wr_en;
   fetch_entry_t  wr_entry;
   fetch_entry_t  rd_entry;

   assign stored     = (cnt != '0);
   assign push_ready = (cnt != FULL);

`ifdef FETCH_QUEUE_BYPASS_EN
   assign byp = !stored & push_valid & !flush;
`else
   assign byp = 1'b0;
`endif

   assign pop_valid = stored | byp;
   assign push_fire = push_valid & push_ready;
   assign pop_fire  = stored & pop_ready;

   // A bypassed word taken by decode this cycle never lands in the array.
   assign wr_en = push_fire & !flush & !(byp & pop_ready);

   assign wr_entry.pc    = push_pc;
   assign wr_entry.instr = push_instr;

   fetch_queue_mem #(
      .DEPTH (DEPTH)
   ) u_mem (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr),
      .wr_data (wr_entry),
      .rd_addr (rd_ptr),
      .rd_data (rd_entry)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop_fire) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         cnt <= cnt + CW'(wr_en) - CW'(pop_fire);
      end
   end

   always_comb begin
      pop_pc    = XLEN'(RESET_PC);
      pop_instr = XLEN'(NOP_INSTR);
      unique case (1'b1)
         stored: begin
            pop_pc    = rd_entry.pc;
            pop_instr = rd_entry.instr;
         end
         byp: begin
            pop_pc    = push_pc;
            pop_instr = push_instr;
         end
         default: ;
      endcase
   end

   assign pop_pc_add8 = pop_pc + XLEN'(8);
   assign count       = cnt;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: vector table, corner sequences, random vs queue model.
// Honours FETCH_QUEUE_BYPASS_EN in both the table and the model.
module tb_fetch_queue;

   localparam int DEPTH = 4;

`ifdef FETCH_QUEUE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        flush = 1'b0;
   logic        push_valid = 1'b0;
   logic [31:0] push_pc = '0;
   logic [31:0] push_instr = '0;
   logic        pop_ready = 1'b0;
   logic        push_ready;
   logic        pop_valid;
   logic [31:0] pop_pc;
   logic [31:0] pop_instr;
   logic [31:0] pop_pc_add8;
   logic [2:0]  count;

   int checks = 0;
   int failures = 0;

   fetch_queue #(.DEPTH(DEPTH), .XLEN(32)) dut (
      .clk         (clk),
      .reset       (reset),
      .flush       (flush),
      .push_valid  (push_valid),
      .push_ready  (push_ready),
      .push_pc     (push_pc),
      .push_instr  (push_instr),
      .pop_valid   (pop_valid),
      .pop_ready   (pop_ready),
      .pop_pc      (pop_pc),
      .pop_instr   (pop_instr),
      .pop_pc_add8 (pop_pc_add8),
      .count       (count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      bit          fl;
      bit          pv;
      logic [31:0] pc;
      logic [31:0] ins;
      bit          pr;
      int          ec;
      bit          epv;
      bit          erdy;
      logic [31:0] epc;
      logic [31:0] eins;
   } vec_t;

   function automatic vec_t mk(bit fl, bit pv, logic [31:0] pc, logic [31:0] ins, bit pr,
                               int ec, bit epv, bit erdy, logic [31:0] epc, logic [31:0] eins);
      vec_t v;
      v.fl = fl; v.pv = pv; v.pc = pc; v.ins = ins; v.pr = pr;
      v.ec = ec; v.epv = epv; v.erdy = erdy; v.epc = epc; v.eins = eins;
      return v;
   endfunction

   typedef struct {
      logic [31:0] pc;
      logic [31:0] ins;
   } ent_t;

   ent_t q[$];

   task automatic drive(bit fl, bit pv, logic [31:0] pc, logic [31:0] ins, bit pr);
      flush = fl; push_valid = pv; push_pc = pc; push_instr = ins; pop_ready = pr;
   endtask

   // One cycle checked against the queue model, then the model advances with the edge.
   task automatic step(bit fl, bit pv, logic [31:0] pc, logic [31:0] ins, bit pr);
      int   n;
      bit   b;
      bit   epv;
      ent_t h;
      ent_t e;
      drive(fl, pv, pc, ins, pr);
      @(negedge clk);
      n = q.size();
      b = BYP && n == 0 && pv && !fl;
      epv = (n > 0) || b;
      h.pc = 32'h0; h.ins = 32'h0;
      if (n > 0) h = q[0];
      else if (b) begin h.pc = pc; h.ins = ins; end
      chk("m_count", 32'(count), 32'(n));
      chk("m_push_ready", 32'(push_ready), 32'(n < DEPTH));
      chk("m_pop_valid", 32'(pop_valid), 32'(epv));
      chk("m_pop_pc", pop_pc, h.pc);
      chk("m_pop_instr", pop_instr, h.ins);
      chk("m_pop_pc_add8", pop_pc_add8, h.pc + 32'd8);
      @(posedge clk);
      if (fl) q.delete();
      else if (!(b && pr)) begin
         if (epv && pr) void'(q.pop_front());
         if (pv && n < DEPTH) begin
            e.pc = pc; e.ins = ins;
            q.push_back(e);
         end
      end
      #1;
   endtask

   vec_t tbl[18];

   initial begin
      tbl[0]  = BYP ? mk(0,1,32'h0040_0000,32'h11,0, 0,1,1,32'h0040_0000,32'h11)
                    : mk(0,1,32'h0040_0000,32'h11,0, 0,0,1,32'h0,32'h0);
      tbl[1]  = mk(0,1,32'h0040_0004,32'h22,0, 1,1,1,32'h0040_0000,32'h11);
      tbl[2]  = mk(0,1,32'h0040_0008,32'h33,0, 2,1,1,32'h0040_0000,32'h11);
      tbl[3]  = mk(0,1,32'h0040_000C,32'h44,0, 3,1,1,32'h0040_0000,32'h11);
      tbl[4]  = mk(0,1,32'h0040_0010,32'h55,0, 4,1,0,32'h0040_0000,32'h11);
      tbl[5]  = mk(0,1,32'h0040_0010,32'h55,1, 4,1,0,32'h0040_0000,32'h11);
      tbl[6]  = mk(0,0,32'h0,32'h0,0, 3,1,1,32'h0040_0004,32'h22);
      tbl[7]  = mk(0,0,32'h0,32'h0,1, 3,1,1,32'h0040_0004,32'h22);
      tbl[8]  = mk(0,0,32'h0,32'h0,1, 2,1,1,32'h0040_0008,32'h33);
      tbl[9]  = mk(0,0,32'h0,32'h0,1, 1,1,1,32'h0040_000C,32'h44);
      tbl[10] = mk(0,0,32'h0,32'h0,1, 0,0,1,32'h0,32'h0);
      tbl[11] = BYP ? mk(0,1,32'h0050_0000,32'hAA,0, 0,1,1,32'h0050_0000,32'hAA)
                    : mk(0,1,32'h0050_0000,32'hAA,0, 0,0,1,32'h0,32'h0);
      tbl[12] = mk(0,1,32'h0050_0004,32'hBB,0, 1,1,1,32'h0050_0000,32'hAA);
      tbl[13] = mk(1,1,32'h0050_0008,32'hCC,1, 2,1,1,32'h0050_0000,32'hAA);
      tbl[14] = mk(0,0,32'h0,32'h0,0, 0,0,1,32'h0,32'h0);
      tbl[15] = BYP ? mk(0,1,32'hFFFF_FFFC,32'h77,0, 0,1,1,32'hFFFF_FFFC,32'h77)
                    : mk(0,1,32'hFFFF_FFFC,32'h77,0, 0,0,1,32'h0,32'h0);
      tbl[16] = mk(0,0,32'h0,32'h0,1, 1,1,1,32'hFFFF_FFFC,32'h77);
      tbl[17] = mk(0,0,32'h0,32'h0,0, 0,0,1,32'h0,32'h0);

      // Reset state
      #12;
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_pop_valid", 32'(pop_valid), 32'd0);
      chk("rst_push_ready", 32'(push_ready), 32'd1);
      chk("rst_pop_pc", pop_pc, 32'h0);
      chk("rst_pop_instr", pop_instr, 32'h0);
      chk("rst_pop_pc_add8", pop_pc_add8, 32'h8);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;

      foreach (tbl[i]) begin
         drive(tbl[i].fl, tbl[i].pv, tbl[i].pc, tbl[i].ins, tbl[i].pr);
         @(negedge clk);
         chk($sformatf("t%0d_count", i), 32'(count), 32'(tbl[i].ec));
         chk($sformatf("t%0d_pop_valid", i), 32'(pop_valid), 32'(tbl[i].epv));
         chk($sformatf("t%0d_push_ready", i), 32'(push_ready), 32'(tbl[i].erdy));
         chk($sformatf("t%0d_pop_pc", i), pop_pc, tbl[i].epc);
         chk($sformatf("t%0d_pop_instr", i), pop_instr, tbl[i].eins);
         chk($sformatf("t%0d_pop_pc_add8", i), pop_pc_add8, tbl[i].epc + 32'd8);
         @(posedge clk);
         #1;
      end
      q.delete();

      // Async reset in the middle of a fill
      step(0, 1, 32'h0070_0000, 32'h1, 0);
      step(0, 1, 32'h0070_0004, 32'h2, 0);
      drive(0, 0, 32'h0, 32'h0, 0);
      #2;
      reset = 1'b0;
      #1;
      chk("mid_rst_count", 32'(count), 32'd0);
      chk("mid_rst_pop_valid", 32'(pop_valid), 32'd0);
      chk("mid_rst_push_ready", 32'(push_ready), 32'd1);
      chk("mid_rst_pop_pc_add8", pop_pc_add8, 32'h8);
      q.delete();
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      step(0, 0, 32'h0, 32'h0, 1);

      // Steady-state push/pop across pointer wrap
      step(0, 1, 32'h0060_0000, 32'h100, 0);
      for (int i = 1; i <= 10; i++) begin
         step(0, 1, 32'h0060_0000 + 32'(4 * i), 32'h100 + 32'(i), 1);
      end
      @(negedge clk);
      chk("wrap_count", 32'(count), 32'd1);
      chk("wrap_head", pop_pc, 32'h0060_0028);
      @(posedge clk);
      #1;
      step(0, 0, 32'h0, 32'h0, 1);

      // Empty-queue push with decode ready
      drive(0, 1, 32'h0040_0100, 32'h2402_0005, 1);
      @(negedge clk);
      chk("byp_pop_valid0", 32'(pop_valid), 32'(BYP));
      chk("byp_pop_pc0", pop_pc, BYP ? 32'h0040_0100 : 32'h0);
      chk("byp_count0", 32'(count), 32'd0);
      @(posedge clk);
      #1;
      drive(0, 0, 32'h0, 32'h0, 1);
      @(negedge clk);
      chk("byp_pop_valid1", 32'(pop_valid), 32'(!BYP));
      chk("byp_pop_instr1", pop_instr, BYP ? 32'h0 : 32'h2402_0005);
      @(posedge clk);
      #1;
      drive(0, 0, 32'h0, 32'h0, 0);
      @(negedge clk);
      chk("byp_count_end", 32'(count), 32'd0);
      @(posedge clk);
      #1;

      // Random traffic against the queue model
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 15) == 0), ($urandom_range(0, 9) < 7), $urandom, $urandom,
              ($urandom_range(0, 9) < 6));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
